// File: rtl/mbist_march_seq_if.sv
// Memory-side bus of the MBIST March C- sequencer: address, write data,
// read/write strobes and read data returned with a fixed one-cycle latency.
interface mbist_march_seq_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Sequencer side drives the strobes and consumes read data.
    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata
    );

    // Memory side.
    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/mbist_march_seq.sv
// March C- sequencer for the MBIST path: walks the six March elements over the
// SRAM under test with a programmable data background and records sticky fail,
// first-fail address/element and a saturating miscompare count.
// Optional build macro MBIST_STOP_ON_FAIL_EN: abort to DONE on the first miscompare.
module mbist_march_seq #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_bg_pattern,
    mbist_march_seq_if.master     mem,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_fail,
    output logic [ADDR_WIDTH-1:0] o_fail_addr,
    output logic [2:0]            o_fail_elem,
    output logic [CNT_WIDTH-1:0]  o_fail_count
);

    localparam logic [ADDR_WIDTH-1:0] AddrMax = '1;
    localparam logic [CNT_WIDTH-1:0]  CntMax  = '1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                r_state, w_state_next;
    logic [2:0]            r_elem, w_elem_next;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
    logic                  r_phase, w_phase_next;
    logic [DATA_WIDTH-1:0] r_bg;

    logic                  r_cmp_valid, w_cmp_valid_next;
    logic [ADDR_WIDTH-1:0] r_cmp_addr;
    logic [2:0]            r_cmp_elem;
    logic [DATA_WIDTH-1:0] r_cmp_exp;

    logic                  r_fail;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [2:0]            r_fail_elem;
    logic [CNT_WIDTH-1:0]  r_fail_count;

    logic                  w_is_read, w_is_write;
    logic [DATA_WIDTH-1:0] w_wdata, w_exp;
    logic                  w_desc, w_two_op, w_op_last, w_addr_last, w_miscompare;
    logic                  w_launch;

    assign w_launch     = (r_state == StIdle) && i_start;
    assign w_desc       = (r_elem == 3'd3) || (r_elem == 3'd4);
    assign w_two_op     = (r_elem >= 3'd1) && (r_elem <= 3'd4);
    assign w_op_last    = !w_two_op || r_phase;
    assign w_addr_last  = w_desc ? (r_addr == '0) : (r_addr == AddrMax);
    assign w_miscompare = r_cmp_valid && (mem.mem_rdata != r_cmp_exp);

    // Decode the current memory operation from element/phase (RUN only).
    always_comb begin
        w_is_read  = 1'b0;
        w_is_write = 1'b0;
        w_wdata    = '0;
        w_exp      = '0;
        if (r_state == StRun) begin
            unique case (r_elem)
                3'd0: begin
                    w_is_write = 1'b1;
                    w_wdata    = r_bg;
                end
                // r0,w1
                3'd1, 3'd3: begin
                    w_is_write = r_phase;
                    w_is_read  = !r_phase;
                    w_wdata    = r_phase ? ~r_bg : '0;
                    w_exp      = r_bg;
                end
                // r1,w0
                3'd2, 3'd4: begin
                    w_is_write = r_phase;
                    w_is_read  = !r_phase;
                    w_wdata    = r_phase ? r_bg : '0;
                    w_exp      = ~r_bg;
                end
                3'd5: begin
                    w_is_read = 1'b1;
                    w_exp     = r_bg;
                end
                default: ;
            endcase
        end
    end

    // Next-state: sequence control and address/element walk.
    always_comb begin
        w_state_next     = r_state;
        w_elem_next      = r_elem;
        w_addr_next      = r_addr;
        w_phase_next     = r_phase;
        w_cmp_valid_next = w_is_read;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StRun;
                    w_elem_next  = 3'd0;
                    w_addr_next  = '0;
                    w_phase_next = 1'b0;
                end
            end
            StRun: begin
                if (!w_op_last) begin
                    w_phase_next = 1'b1;
                end else begin
                    w_phase_next = 1'b0;
                    if (!w_addr_last) begin
                        w_addr_next = w_desc ? r_addr - 1'b1 : r_addr + 1'b1;
                    end else if (r_elem == 3'd5) begin
                        w_state_next = StDrain;
                    end else begin
                        w_elem_next = r_elem + 3'd1;
                        // E3 and E4 walk downwards from the top address.
                        w_addr_next = ((r_elem == 3'd2) || (r_elem == 3'd3)) ? AddrMax : '0;
                    end
                end
`ifdef MBIST_STOP_ON_FAIL_EN
                if (w_miscompare) begin
                    w_state_next     = StDone;
                    w_cmp_valid_next = 1'b0;
                end
`endif
            end
            StDrain: w_state_next = StDone;
            StDone: begin
                if (!i_start) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Sequencer state, walk counters and background latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_elem  <= '0;
            r_addr  <= '0;
            r_phase <= 1'b0;
            r_bg    <= '0;
        end else begin
            r_state <= w_state_next;
            r_elem  <= w_elem_next;
            r_addr  <= w_addr_next;
            r_phase <= w_phase_next;
            if (w_launch) begin
                r_bg <= i_bg_pattern;
            end
        end
    end

    // Compare pipeline: remember what each read should return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_valid <= 1'b0;
            r_cmp_addr  <= '0;
            r_cmp_elem  <= '0;
            r_cmp_exp   <= '0;
        end else begin
            r_cmp_valid <= w_cmp_valid_next;
            if (w_is_read) begin
                r_cmp_addr <= r_addr;
                r_cmp_elem <= r_elem;
                r_cmp_exp  <= w_exp;
            end
        end
    end

    // Result registers: cleared at launch, updated on each miscompare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail       <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_elem  <= '0;
            r_fail_count <= '0;
        end else if (w_launch) begin
            r_fail       <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_elem  <= '0;
            r_fail_count <= '0;
        end else if (w_miscompare) begin
            r_fail <= 1'b1;
            if (!r_fail) begin
                r_fail_addr <= r_cmp_addr;
                r_fail_elem <= r_cmp_elem;
            end
            if (r_fail_count != CntMax) begin
                r_fail_count <= r_fail_count + 1'b1;
            end
        end
    end

    assign mem.mem_we    = w_is_write;
    assign mem.mem_re    = w_is_read;
    assign mem.mem_wdata = w_wdata;
    assign mem.mem_addr  = (r_state == StRun) ? r_addr : '0;

    assign o_busy       = (r_state == StRun) || (r_state == StDrain);
    assign o_done       = (r_state == StDone);
    assign o_fail       = r_fail;
    assign o_fail_addr  = r_fail_addr;
    assign o_fail_elem  = r_fail_elem;
    assign o_fail_count = r_fail_count;

endmodule

// File: tb/tb_mbist_march_seq.sv
// Scoreboard bench for mbist_march_seq: a 16x8 SRAM model with an optional
// stuck-at-1 on bit 0 of address 5, expected ops/results queued at launch and
// checked by an independent negedge monitor.
module tb_mbist_march_seq;

    typedef struct packed {
        logic       we;
        logic       re;
        logic [3:0] addr;
        logic [7:0] wdata;
    } op_t;

    typedef struct {
        int fail;
        int faddr;
        int felem;
        int fcnt;
        int lat;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] bg = 8'h00;
    logic       busy, done, fail;
    logic [3:0] fail_addr;
    logic [2:0] fail_elem;
    logic [3:0] fail_count;
    logic       fault_en = 1'b0;
    logic [7:0] mem [16];

    int   n_cmp = 0;
    int   n_bad = 0;
    op_t  exp_ops[$];
    res_t exp_res[$];

    mbist_march_seq_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) mem_if ();

    mbist_march_seq #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_bg_pattern (bg),
        .mem          (mem_if),
        .o_busy       (busy),
        .o_done       (done),
        .o_fail       (fail),
        .o_fail_addr  (fail_addr),
        .o_fail_elem  (fail_elem),
        .o_fail_count (fail_count)
    );

    always #5 clk = ~clk;

    // SRAM model, read latency 1, optional stuck-at-1 on addr 5 bit 0.
    always @(posedge clk) begin
        if (mem_if.mem_we) mem[mem_if.mem_addr] <= mem_if.mem_wdata;
        if (mem_if.mem_re)
            mem_if.mem_rdata <= mem[mem_if.mem_addr] |
                                {7'b0, fault_en && (mem_if.mem_addr == 4'd5)};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Expected March C- op stream, truncated to the first 'limit' ops.
    task automatic push_ops(input logic [7:0] b, input int limit);
        int         n;
        op_t        o;
        logic [3:0] a;
        logic [7:0] wd;
        n = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 16; i++) begin
                a  = (e == 3 || e == 4) ? 4'(15 - i) : 4'(i);
                wd = (e == 0 || e == 2 || e == 4) ? b : ~b;
                if (e != 0 && n < limit) begin
                    o = '{we: 1'b0, re: 1'b1, addr: a, wdata: 8'h00};
                    exp_ops.push_back(o);
                    n++;
                end
                if (e != 5 && n < limit) begin
                    o = '{we: 1'b1, re: 1'b0, addr: a, wdata: wd};
                    exp_ops.push_back(o);
                    n++;
                end
            end
        end
    endtask

    task automatic push_res(input int f, input int fa, input int fe, input int fc, input int lat);
        res_t r;
        r = '{fail: f, faddr: fa, felem: fe, fcnt: fc, lat: lat};
        exp_res.push_back(r);
    endtask

    // Raise start before edge e0; drop it after e0 when pulsing.
    task automatic launch(input logic [7:0] b, input bit pulse);
        @(negedge clk);
        bg    = b;
        start = 1'b1;
        @(negedge clk);
        if (pulse) start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", {31'b0, done}, 32'd1);
    endtask

    // Monitor: pops expected ops on each strobe, expected results on done rise.
    initial begin
        op_t  o;
        res_t r;
        logic prev_busy, prev_done;
        int   k;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        k = 0;
        forever begin
            @(negedge clk);
            if (busy && !prev_busy) k = 0;
            else k++;
            if (mem_if.mem_we || mem_if.mem_re) begin
                if (exp_ops.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL op_unexpected: got we=%0b re=%0b addr=%0h, required no op",
                             mem_if.mem_we, mem_if.mem_re, mem_if.mem_addr);
                end else begin
                    o = exp_ops.pop_front();
                    check("op_we", {31'b0, mem_if.mem_we}, {31'b0, o.we});
                    check("op_re", {31'b0, mem_if.mem_re}, {31'b0, o.re});
                    check("op_addr", {28'b0, mem_if.mem_addr}, {28'b0, o.addr});
                    if (o.we) check("op_wdata", {24'b0, mem_if.mem_wdata}, {24'b0, o.wdata});
                    check("op_busy", {31'b0, busy}, 32'd1);
                end
            end
            if (done && !prev_done) begin
                if (exp_res.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_unexpected: got done=1, required done=0");
                end else begin
                    r = exp_res.pop_front();
                    check("res_fail", {31'b0, fail}, r.fail);
                    check("res_fail_addr", {28'b0, fail_addr}, r.faddr);
                    check("res_fail_elem", {29'b0, fail_elem}, r.felem);
                    check("res_fail_count", {28'b0, fail_count}, r.fcnt);
                    check("res_latency", k, r.lat);
                    check("res_ops_left", exp_ops.size(), 32'd0);
                end
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_fail", {31'b0, fail}, 32'd0);
        check("rst_fail_count", {28'b0, fail_count}, 32'd0);
        check("rst_we_re", {30'b0, mem_if.mem_we, mem_if.mem_re}, 32'd0);
        check("rst_addr", {28'b0, mem_if.mem_addr}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean pass, bg=00, one-cycle start pulse.
        push_ops(8'h00, 160);
        push_res(0, 0, 0, 0, 161);
        launch(8'h00, 1'b1);
        wait_done(400);
        repeat (3) @(negedge clk);
        check("idle_after_pulse", {31'b0, done}, 32'd0);

        // Clean pass, bg=A5, start held through DONE.
        push_ops(8'hA5, 160);
        push_res(0, 0, 0, 0, 161);
        launch(8'hA5, 1'b0);
        wait_done(400);
        repeat (5) @(negedge clk);
        check("done_held", {31'b0, done}, 32'd1);
        check("no_restart_busy", {31'b0, busy}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        check("done_cleared", {31'b0, done}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);

        // Stuck-at-1 at addr 5 bit 0.
        fault_en = 1'b1;
`ifdef MBIST_STOP_ON_FAIL_EN
        push_ops(8'h00, 28);
        push_res(1, 5, 1, 1, 28);
`else
        push_ops(8'h00, 160);
        push_res(1, 5, 1, 3, 161);
`endif
        launch(8'h00, 1'b1);
        wait_done(400);
        repeat (10) @(negedge clk);
        fault_en = 1'b0;

        // Reset at cycle 50 of RUN.
        push_ops(8'h3C, 160);
        launch(8'h3C, 1'b1);
        repeat (50) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_we_re", {30'b0, mem_if.mem_we, mem_if.mem_re}, 32'd0);
        check("midrst_addr", {28'b0, mem_if.mem_addr}, 32'd0);
        check("midrst_wdata", {24'b0, mem_if.mem_wdata}, 32'd0);
        check("midrst_fail_count", {28'b0, fail_count}, 32'd0);
        exp_ops.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fresh clean pass; start pulsed again mid-RUN must be ignored.
        push_ops(8'h3C, 160);
        push_res(0, 0, 0, 0, 161);
        launch(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        repeat (5) @(negedge clk);
        check("final_ops_left", exp_ops.size(), 32'd0);
        check("final_res_left", exp_res.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mbist_march_seq.md
Name: mbist_march_seq

Overview:
- March C- sequencer for the on-chip MBIST path.
- Sits upstream of the 16x8 SRAM under test. It generates address, write data and read/write strobes, and checks the returned read data against the expected pattern.
- It supersedes the single-pass write/read FSM: it applies the full 6-element March C- algorithm using a programmable data background.
- Results are reported as sticky fail flag, first-fail address/element and a saturating miscompare count, for export on uo_out.

Parameters:
- ADDR_WIDTH, 4, memory address width; N = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, memory word width.
- CNT_WIDTH, 4, miscompare counter width (saturating).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level start request; sampled only in IDLE.
- bg_pattern  input  DATA_WIDTH  data background; "0" = bg_pattern, "1" = ~bg_pattern. Sampled at the start edge.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_we  output  1  write strobe.
- mem_re  output  1  read strobe.
- mem_rdata  input  DATA_WIDTH  read data, valid the cycle after mem_re (fixed latency 1).
- busy  output  1  sequence in progress (RUN or DRAIN).
- done  output  1  sequence complete; held until start deasserts.
- fail  output  1  sticky: at least one miscompare.
- fail_addr  output  ADDR_WIDTH  address of first miscompare.
- fail_elem  output  3  March element (0-5) of first miscompare.
- fail_count  output  CNT_WIDTH  miscompare count, saturating at all-ones.

Behaviour:
- Reset (async) values:
  - state = IDLE.
  - All outputs 0: mem_we, mem_re, mem_addr, mem_wdata, busy, done, fail, fail_addr, fail_elem, fail_count.
  - Internal counters and the compare pipeline are cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On a clock edge with start=1: latch bg_pattern, clear fail/fail_addr/fail_elem/fail_count, set elem=0, addr=0, phase=0, go to RUN.
- RUN, one memory operation per cycle. mem_* are decoded combinationally from the registered elem/addr/phase:
  - E0 ⇑ w0: N cycles.
  - E1 ⇑ (r0,w1).
  - E2 ⇑ (r1,w0).
  - E3 ⇓ (r0,w1).
  - E4 ⇓ (r1,w0).
  - E5 ⇑ r0: N cycles.
  - E1-E4 take 2N cycles each: read at phase 0, write at the same address at phase 1.
  - ⇑ runs addr 0→N-1; ⇓ runs N-1→0. Each element starts at its first address; no idle cycle between elements.
  - Total RUN = 10N cycles (160 for N=16).
  - After the last E5 read: go to DRAIN.
- Exactly one of mem_we/mem_re is high in every RUN cycle. Both are low in IDLE, DRAIN and DONE.
- Compare pipeline:
  - On the edge ending a read cycle, register valid, address, element and expected data.
  - On the next edge, if valid and mem_rdata != expected, count a miscompare.
  - On a miscompare: fail←1 and fail_count increments, saturating.
  - fail_addr/fail_elem are captured only when fail was 0.
- DRAIN: one cycle to complete the last compare, then DONE.
- DONE: done=1, busy=0, results held. start=0 returns to IDLE and clears done. Results persist until the next start.
- Timing: start sampled at edge e0 → busy=1 after e0 → done=1 after edge e(10N+1) (e161 for N=16).
- start during RUN/DRAIN is ignored. start held high in DONE stays in DONE; there is no auto-restart.
- rst_n low mid-sequence: immediate return to IDLE with all outputs cleared. The memory contents are not touched.

Optional Feature:
- Macro: MBIST_STOP_ON_FAIL_EN.
- Defined: on the first miscompare, abort RUN and go directly to DONE on the edge where the miscompare is registered. No further memory ops are issued; fail_count=1.
- Undefined: the full algorithm always completes and counts all miscompares.

Test Plan:
- Fault-free 16x8 model, bg=0x00, start pulse → 160 ops with order and data exactly per March C- (E1 reads 0x00, writes 0xFF); done=1 at e161; fail=0; fail_count=0.
- bg=0xA5, fault-free → w0 data 0xA5, w1 data 0x5A; E3 addresses descend 15→0; done with fail=0.
- Bit0 of addr 5 stuck-at-1, bg=0x00 → fail=1, fail_addr=5, fail_elem=1, fail_count=3 (E1, E3, E5 reads).
- Same fault with MBIST_STOP_ON_FAIL_EN defined → done asserted 2 cycles after the E1 read of addr 5; fail_count=1; no mem_we/mem_re afterwards.
- Assert rst_n low at cycle 50 of RUN → all outputs 0 immediately. After release, a new start runs a full clean pass with fail=0.
- start held high through DONE → stays DONE, done=1. Pulse start during RUN → no restart, same 161-cycle timing. start low → IDLE, done=0.
